nx_fifo_rd_sched: RTL and testbench

NX_FIFO_RD_SCHED -- requirements
Module: nx_fifo_rd_sched

---
 rtl/nx_fifo_sched_pkg.sv | 8 +
 rtl/nx_rr_arb.sv | 28 ++
 rtl/nx_fifo_rd_sched.sv | 94 +++++++++
 tb/tb_nx_fifo_rd_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nx_fifo_sched_pkg.sv
// nx_fifo_sched_pkg: scheduler state encoding, sticky error bit positions
// and credit counter width shared by the FIFO read scheduler files.
package nx_fifo_sched_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} sched_state_e;
   localparam int ERR_UFLOW = 0;
   localparam int ERR_COVF  = 1;
   localparam int CREDIT_W  = 3;
endpackage

// File: rtl/nx_rr_arb.sv
// nx_rr_arb: picks the first set request at or after ptr, wrapping modulo N,
// and reports it as a one-hot grant plus its index.
module nx_rr_arb #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic [W-1:0] idx,
   output logic         valid
);
   logic [W-1:0] w_j;
   always_comb begin
      gnt   = '0;
      idx   = '0;
      valid = 1'b0;
      w_j   = '0;
      for (int i = 0; i < N; i++) begin
         w_j = W'((int'(ptr) + i) % N);
         if (!valid && req[w_j]) begin
            valid    = 1'b1;
            gnt[w_j] = 1'b1;
            idx      = w_j;
         end
      end
   end
endmodule

// File: rtl/nx_fifo_rd_sched.sv
// nx_fifo_rd_sched: credit-gated round-robin read scheduler over N_FIFO FIFO controllers.
// Defining NX_FIFO_RD_SCHED_STALL_CNT_EN adds the stall_cnt output and its counter.
module nx_fifo_rd_sched
   import nx_fifo_sched_pkg::*;
#(
   parameter int N_FIFO      = 4,
   parameter int MAX_CREDITS = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [N_FIFO-1:0]         fifo_empty,
   input  logic [N_FIFO-1:0]         fifo_underflow,
   input  logic                      credit_return,
   output logic [N_FIFO-1:0]         fifo_ren,
   output logic                      grant_valid,
   output logic [$clog2(N_FIFO)-1:0] grant_id,
   output logic [CREDIT_W-1:0]       credits,
   output logic                      busy,
`ifdef NX_FIFO_RD_SCHED_STALL_CNT_EN
   output logic [15:0]               stall_cnt,
`endif
   output logic [1:0]                err
);
   localparam int W = $clog2(N_FIFO);
   localparam logic [CREDIT_W-1:0] MAX_C = CREDIT_W'(MAX_CREDITS);

   sched_state_e        r_state, w_state_nxt;
   logic [W-1:0]        r_rr_ptr, r_grant_id, w_idx;
   logic [CREDIT_W-1:0] r_credits, w_credits_nxt;
   logic [N_FIFO-1:0]   w_req;
   logic [1:0]          r_err;
   logic                r_grant_valid, w_grant, w_covf;

   assign w_req = (r_state == RUN && r_credits != '0) ? ~fifo_empty : '0;

   nx_rr_arb #(.N(N_FIFO), .W(W)) u_arb (
      .req   (w_req),
      .ptr   (r_rr_ptr),
      .gnt   (fifo_ren),
      .idx   (w_idx),
      .valid (w_grant)
   );

   always_comb begin
      w_state_nxt = enable ? RUN :
                    (r_state == RUN || (r_state == DRAIN && r_credits != MAX_C)) ? DRAIN : IDLE;
   end

   // a return with no same-cycle grant at a full pool is dropped and flagged
   always_comb begin
      w_covf        = credit_return && !w_grant && r_credits == MAX_C;
      w_credits_nxt = (w_grant && !credit_return) ? r_credits - 1'b1 :
                      (!w_grant && credit_return && !w_covf) ? r_credits + 1'b1 : r_credits;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_rr_ptr      <= '0;
         r_credits     <= MAX_C;
         r_grant_valid <= 1'b0;
         r_grant_id    <= '0;
         r_err         <= '0;
      end else begin
         r_state                <= w_state_nxt;
         r_credits              <= w_credits_nxt;
         r_grant_valid          <= w_grant;
         r_err[ERR_UFLOW]       <= r_err[ERR_UFLOW] | (|fifo_underflow);
         r_err[ERR_COVF]        <= r_err[ERR_COVF] | w_covf;
         if (w_grant) begin
            r_rr_ptr   <= (w_idx == W'(N_FIFO - 1)) ? '0 : w_idx + 1'b1;
            r_grant_id <= w_idx;
         end
      end
   end

   assign grant_valid = r_grant_valid;
   assign grant_id    = r_grant_id;
   assign credits     = r_credits;
   assign busy        = r_state != IDLE;
   assign err         = r_err;

`ifdef NX_FIFO_RD_SCHED_STALL_CNT_EN
   logic [15:0] r_stall_cnt;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_stall_cnt <= '0;
      else if (r_state == RUN && r_credits == '0 && fifo_empty != '1 && r_stall_cnt != 16'hFFFF)
         r_stall_cnt <= r_stall_cnt + 1'b1;
   end
   assign stall_cnt = r_stall_cnt;
`endif
endmodule

// File: tb/tb_nx_fifo_rd_sched.sv
// tb_nx_fifo_rd_sched: directed scenarios plus a randomized run checked against
// a cycle-level behavioural model of the read scheduler.
module tb_nx_fifo_rd_sched;
   localparam int N    = 4;
   localparam int MAXC = 4;

   logic         clk = 1'b0, rst_n = 1'b0, enable = 1'b0, credit_return = 1'b0;
   logic [N-1:0] fifo_empty = '1, fifo_underflow = '0;
   logic [N-1:0] fifo_ren;
   logic         grant_valid, busy;
   logic [1:0]   grant_id, err;
   logic [2:0]   credits;

   int vectors = 0, miscompares = 0;

   int         m_state = 0, m_cred = MAXC, m_ptr = 0, m_gid = 0;
   logic       m_gv = 1'b0;
   logic [1:0] m_err = '0;

   always #5 clk = ~clk;

   nx_fifo_rd_sched #(.N_FIFO(N), .MAX_CREDITS(MAXC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .enable         (enable),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .credit_return  (credit_return),
      .fifo_ren       (fifo_ren),
      .grant_valid    (grant_valid),
      .grant_id       (grant_id),
      .credits        (credits),
      .busy           (busy),
      .err            (err)
   );

   // model states: 0 idle, 1 run, 2 drain; returns granted FIFO or -1
   function automatic int pick();
      if (m_state != 1 || m_cred == 0) return -1;
      for (int i = 0; i < N; i++)
         if (!fifo_empty[(m_ptr + i) % N]) return (m_ptr + i) % N;
      return -1;
   endfunction

   function automatic logic [N-1:0] exp_ren();
      int g;
      g = pick();
      return (g < 0) ? '0 : N'(1 << g);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_state = 0; m_cred = MAXC; m_ptr = 0; m_gid = 0; m_gv = 1'b0; m_err = '0;
      end else begin
         int g;
         g = pick();
         m_gv = g >= 0;
         if (g >= 0) begin m_gid = g; m_ptr = (g + 1) % N; end
         if (enable) m_state = 1;
         else if (m_state == 1) m_state = 2;
         else if (m_state == 2 && m_cred == MAXC) m_state = 0;
         if (g >= 0 && !credit_return) m_cred--;
         else if (g < 0 && credit_return) begin
            if (m_cred == MAXC) m_err[1] = 1'b1;
            else m_cred++;
         end
         if (|fifo_underflow) m_err[0] = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input logic en, input logic [N-1:0] emp, input logic [N-1:0] uf, input logic cr);
      enable = en; fifo_empty = emp; fifo_underflow = uf; credit_return = cr;
   endtask

   task automatic do_reset();
      drive(1'b0, '1, '0, 1'b0);
      rst_n = 1'b0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      drive(1'b1, '0, '0, 1'b0);
      tick(); tick();
      #1 rst_n = 1'b0;
      #1;
      vectors++; if (fifo_ren !== 4'b0000) begin miscompares++; $display("FAIL reset ren got %b exp 0000", fifo_ren); end
      vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL reset grant_valid got %b exp 0", grant_valid); end
      vectors++; if (grant_id !== 2'd0) begin miscompares++; $display("FAIL reset grant_id got %0d exp 0", grant_id); end
      vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL reset credits got %0d exp 4", credits); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset busy got %b exp 0", busy); end
      vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL reset err got %b exp 00", err); end
      do_reset();
   endtask

   task automatic test_empty();
      do_reset();
      drive(1'b1, '1, '0, 1'b0);
      tick();
      repeat (2) begin
         vectors++; if (fifo_ren !== 4'b0000) begin miscompares++; $display("FAIL empty ren got %b exp 0000", fifo_ren); end
         vectors++; if (credits !== 3'd4) begin miscompares++; $display("FAIL empty credits got %0d exp 4", credits); end
         vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL empty busy got %b exp 1", busy); end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      drive(1'b1, '0, '0, 1'b0);
      tick();
      for (int k = 0; k < 4; k++) begin
         vectors++; if (fifo_ren !== 4'(1 << k)) begin miscompares++; $display("FAIL b2b ren[%0d] got %b exp %b", k, fifo_ren, 4'(1 << k)); end
         vectors++; if (credits !== 3'(4 - k)) begin miscompares++; $display("FAIL b2b credits[%0d] got %0d exp %0d", k, credits, 4 - k); end
         if (k > 0) begin
            vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'(k - 1)) begin miscompares++; $display("FAIL b2b grant[%0d] got %b/%0d exp 1/%0d", k, grant_valid, grant_id, k - 1); end
         end
         tick();
      end
      vectors++; if (fifo_ren !== 4'b0000 || credits !== 3'd0) begin miscompares++; $display("FAIL b2b exhausted ren/credits got %b/%0d exp 0000/0", fifo_ren, credits); end
      vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin miscompares++; $display("FAIL b2b last grant got %b/%0d exp 1/3", grant_valid, grant_id); end
      tick();
      vectors++; if (grant_valid !== 1'b0) begin miscompares++; $display("FAIL b2b idle grant_valid got %b exp 0", grant_valid); end
   endtask

   task automatic test_pattern();
      do_reset();
      drive(1'b1, 4'b1110, '0, 1'b0);
      tick();
      vectors++; if (fifo_ren !== 4'b0001) begin miscompares++; $display("FAIL pattern setup ren got %b exp 0001", fifo_ren); end
      tick();
      fifo_empty = 4'b1010;
      #1;
      vectors++; if (fifo_ren !== 4'b0100) begin miscompares++; $display("FAIL pattern ren from ptr1 got %b exp 0100", fifo_ren); end
      tick();
      vectors++; if (fifo_ren !== 4'b0001) begin miscompares++; $display("FAIL pattern wrap ren got %b exp 0001", fifo_ren); end
      vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin miscompares++; $display("FAIL pattern grant got %b/%0d exp 1/2", grant_valid, grant_id); end
      tick();
      vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || credits !== 3'd1) begin miscompares++; $display("FAIL pattern wrap grant got %b/%0d cr %0d exp 1/0 cr 1", grant_valid, grant_id, credits); end
   endtask

   task automatic test_credit();
      do_reset();
      drive(1'b1, '0, '0, 1'b0);
      repeat (5) tick();
      vectors++; if (fifo_ren !== 4'b0000 || credits !== 3'd0) begin miscompares++; $display("FAIL credit starved got %b/%0d exp 0000/0", fifo_ren, credits); end
      credit_return = 1'b1;
      tick();
      vectors++; if (credits !== 3'd1 || fifo_ren !== 4'b0001) begin miscompares++; $display("FAIL credit return got cr %0d ren %b exp cr 1 ren 0001", credits, fifo_ren); end
      tick();
      credit_return = 1'b0;
      #1;
      vectors++; if (credits !== 3'd1) begin miscompares++; $display("FAIL credit grant+return got %0d exp 1", credits); end
      vectors++; if (grant_valid !== 1'b1 || grant_id !== 2'd0 || fifo_ren !== 4'b0010) begin miscompares++; $display("FAIL credit next grant got %b/%0d ren %b exp 1/0 ren 0010", grant_valid, grant_id, fifo_ren); end
   endtask

   task automatic test_drain();
      do_reset();
      drive(1'b1, '0, '0, 1'b0);
      tick();
      tick();
      enable = 1'b0;
      #1;
      vectors++; if (fifo_ren !== 4'b0010) begin miscompares++; $display("FAIL drain last run ren got %b exp 0010", fifo_ren); end
      tick();
      vectors++; if (busy !== 1'b1 || fifo_ren !== 4'b0000 || credits !== 3'd2) begin miscompares++; $display("FAIL drain entry busy %b ren %b cr %0d exp 1 0000 2", busy, fifo_ren, credits); end
      credit_return = 1'b1;
      tick();
      vectors++; if (credits !== 3'd3 || fifo_ren !== 4'b0000) begin miscompares++; $display("FAIL drain ret1 cr %0d ren %b exp 3 0000", credits, fifo_ren); end
      tick();
      credit_return = 1'b0;
      #1;
      vectors++; if (credits !== 3'd4 || busy !== 1'b1) begin miscompares++; $display("FAIL drain ret2 cr %0d busy %b exp 4 1", credits, busy); end
      tick();
      vectors++; if (busy !== 1'b0 || fifo_ren !== 4'b0000) begin miscompares++; $display("FAIL drain idle busy %b ren %b exp 0 0000", busy, fifo_ren); end
   endtask

   task automatic test_err();
      do_reset();
      drive(1'b0, '1, '0, 1'b1);
      tick();
      credit_return = 1'b0;
      #1;
      vectors++; if (err !== 2'b10 || credits !== 3'd4) begin miscompares++; $display("FAIL err overflow err %b cr %0d exp 10 4", err, credits); end
      fifo_underflow = 4'b0100;
      tick();
      fifo_underflow = '0;
      vectors++; if (err !== 2'b11) begin miscompares++; $display("FAIL err underflow got %b exp 11", err); end
      repeat (3) tick();
      vectors++; if (err !== 2'b11) begin miscompares++; $display("FAIL err sticky got %b exp 11", err); end
      rst_n = 1'b0;
      #1;
      vectors++; if (err !== 2'b00) begin miscompares++; $display("FAIL err clear got %b exp 00", err); end
      do_reset();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 600; i++) begin
         tick();
         drive((i % 100) < 75 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0),
               N'($urandom), ($urandom_range(0, 63) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0,
               1'($urandom_range(0, 1)));
         if (i == 300) rst_n = 1'b0;
         #1;
         vectors++; if (fifo_ren !== exp_ren()) begin miscompares++; $display("FAIL rand ren @%0d got %b exp %b", i, fifo_ren, exp_ren()); end
         vectors++; if (grant_valid !== m_gv) begin miscompares++; $display("FAIL rand grant_valid @%0d got %b exp %b", i, grant_valid, m_gv); end
         if (m_gv) begin
            vectors++; if (grant_id !== 2'(m_gid)) begin miscompares++; $display("FAIL rand grant_id @%0d got %0d exp %0d", i, grant_id, m_gid); end
         end
         vectors++; if (credits !== 3'(m_cred)) begin miscompares++; $display("FAIL rand credits @%0d got %0d exp %0d", i, credits, m_cred); end
         vectors++; if (busy !== (m_state != 0)) begin miscompares++; $display("FAIL rand busy @%0d got %b exp %b", i, busy, m_state != 0); end
         vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rand err @%0d got %b exp %b", i, err, m_err); end
         if (i == 300) begin @(negedge clk); rst_n = 1'b1; end
      end
   endtask

   initial begin
      test_reset();
      test_empty();
      test_back_to_back();
      test_pattern();
      test_credit();
      test_drain();
      test_err();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
